// File: rtl/pipe_pkg.sv
// pipe_pkg: shared field widths, control-vector layout and per-stage payload sizes for pipe_stage_reg.
package pipe_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int ALUOP_W = 6;
  localparam int OPCODE_W = 6;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_JUMP = 2;
  localparam int CTRL_BRANCH = 3;
  localparam int CTRL_BRANCHNOT = 4;
  localparam int CTRL_MEMREAD = 5;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_REGDST = 7;
  localparam int CTRL_ALUOP_LO = 8;
  localparam int CTRL_ALUSRC = CTRL_ALUOP_LO + ALUOP_W;
  localparam int CTRL_OPCODE_LO = CTRL_ALUSRC + 1;
  localparam int CTRL_W = CTRL_OPCODE_LO + OPCODE_W;
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
  typedef enum logic [1:0] {STAGE_ID_EX, STAGE_EX_MEM, STAGE_MEM_WB} stage_e;
  localparam int ID_EX_DW = 5 * XLEN + 2 * REG_ADDR_W;
  localparam int ID_EX_CW = CTRL_W;
  localparam int EX_MEM_DW = 3 * XLEN + REG_ADDR_W;
  localparam int EX_MEM_CW = CTRL_REGDST;
  localparam int MEM_WB_DW = 2 * XLEN + REG_ADDR_W;
  localparam int MEM_WB_CW = CTRL_JUMP;
  function automatic int stage_dw(stage_e s);
    return s == STAGE_ID_EX ? ID_EX_DW : s == STAGE_EX_MEM ? EX_MEM_DW : MEM_WB_DW;
  endfunction
  function automatic int stage_cw(stage_e s);
    return s == STAGE_ID_EX ? ID_EX_CW : s == STAGE_EX_MEM ? EX_MEM_CW : MEM_WB_CW;
  endfunction
endpackage

// File: rtl/pipe_stage_reg_skid.sv
// pipe_skid_buf: one-entry holding register with valid; ctrl is zeroed whenever the entry is emptied.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DW = ID_EX_DW,
  parameter int CW = ID_EX_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic [CW-1:0] in_ctrl,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] ctrl
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data <= '0;
      ctrl <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data <= in_data;
      ctrl <= in_ctrl;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, hazard bubble and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry that cuts the out_ready -> in_ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DW = ID_EX_DW,
  parameter int CW = ID_EX_CW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_ctrl,
  input  logic             flush,
  input  logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);
  logic          advance;
  logic          in_xfer;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic [CW-1:0] src_ctrl;
  assign advance = out_ready | ~out_valid;
  assign in_xfer = in_valid & in_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic [CW-1:0] skid_ctrl;
  assign in_ready = ~skid_valid & ~bubble;
  pipe_skid_buf #(.DW(DW), .CW(CW)) u_skid (
    .clk(clk),
    .reset(reset),
    .clear(flush | (advance & skid_valid)),
    .load(in_xfer & ~advance & ~flush),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .valid(skid_valid),
    .data(skid_data),
    .ctrl(skid_ctrl)
  );
  // The older skid beat always refills the main entry ahead of new input.
  assign src_valid = skid_valid | in_xfer;
  assign src_data = skid_valid ? skid_data : in_data;
  assign src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
`else
  assign in_ready = flush | (~bubble & advance);
  assign src_valid = in_xfer;
  assign src_data = in_data;
  assign src_ctrl = in_ctrl;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ctrl <= CW'(CTRL_NOP);
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl <= CW'(CTRL_NOP);
    end else if (advance) begin
      out_valid <= src_valid;
      out_data <= src_valid ? src_data : out_data;
      out_ctrl <= src_valid ? src_ctrl : CW'(CTRL_NOP);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus against a queue-based reference of pipe_stage_reg.
module tb_pipe_stage_reg;
  localparam int DW = 170;
  localparam int CW = 21;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic flush = 1'b0;
  logic bubble = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
  beat_t q[$];
  int cnt_m = 0;
  int checks = 0;
  int failures = 0;
  pipe_stage_reg #(.DW(DW), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .flush(flush), .bubble(bubble),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit exp_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < CAP && !bubble;
`else
    return flush || (!bubble && (out_ready || q.size() == 0));
`endif
  endfunction
  task automatic cycle();
    bit er;
    bit was_reset;
    er = exp_ready();
    #1 chk("in_ready", DW'(in_ready), DW'(er));
    @(posedge clk);
    was_reset = reset;
    if (reset) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (q.size() > 0 && !out_ready && cnt_m < CNT_MAX) cnt_m++;
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && er) q.push_back('{in_data, in_ctrl});
      end
    end
    #1;
    chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
    chk("out_ctrl", DW'(out_ctrl), q.size() > 0 ? DW'(q[0].c) : '0);
    if (q.size() > 0) chk("out_data", out_data, q[0].d);
    if (was_reset) chk("rst_data", out_data, '0);
    chk("stall_cnt", DW'(stall_cnt), DW'(cnt_m));
  endtask
  task automatic put(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic r);
    in_valid = v;
    in_data = d;
    in_ctrl = c;
    out_ready = r;
    cycle();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    bubble = 1'b0;
    cycle();
    reset = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) put(1'b1, DW'(i), CW'(1), 1'b1);
    put(1'b0, '0, '0, 1'b1);
    chk("t1_cnt", DW'(stall_cnt), '0);
    do_reset();
    put(1'b1, DW'('hA5), CW'(1), 1'b1);
    for (int i = 0; i < 3; i++) put(1'b1, DW'('h5A), CW'(2), 1'b0);
    chk("t2_cnt", DW'(stall_cnt), DW'(3));
    chk("t2_hold", out_data, DW'('hA5));
    put(1'b1, DW'('h5A), CW'(2), 1'b1);
    for (int i = 0; i < 3; i++) put(1'b0, '0, '0, 1'b1);
    do_reset();
    put(1'b1, DW'('h77), CW'('h1FFFFF), 1'b0);
    flush = 1'b1;
    put(1'b1, DW'('h99), CW'(3), 1'b0);
    flush = 1'b0;
    chk("t3_ctrl", DW'(out_ctrl), '0);
    for (int i = 0; i < 2; i++) put(1'b0, '0, '0, 1'b1);
    do_reset();
    put(1'b1, DW'('h11), CW'(1), 1'b1);
    bubble = 1'b1;
    put(1'b1, DW'('h33), CW'(5), 1'b1);
    bubble = 1'b0;
    chk("t4_nop", DW'(out_valid), '0);
    put(1'b1, DW'('h33), CW'(5), 1'b1);
    chk("t4_data", out_data, DW'('h33));
    put(1'b0, '0, '0, 1'b1);
    do_reset();
    put(1'b1, DW'('h44), CW'(1), 1'b1);
    for (int i = 0; i < 20; i++) put(1'b0, '0, '0, 1'b0);
    chk("t5_sat", DW'(stall_cnt), DW'(CNT_MAX));
    reset = 1'b1;
    flush = 1'b1;
    bubble = 1'b1;
    put(1'b1, DW'('h55), CW'(7), 1'b1);
    reset = 1'b0;
    flush = 1'b0;
    bubble = 1'b0;
    chk("t5_rst_cnt", DW'(stall_cnt), '0);
`ifdef PIPE_STAGE_SKID_EN
    do_reset();
    put(1'b1, DW'(1), CW'(1), 1'b0);
    put(1'b1, DW'(2), CW'(1), 1'b0);
    put(1'b1, DW'(3), CW'(1), 1'b0);
    chk("t6_full", DW'(in_ready), '0);
    put(1'b0, '0, '0, 1'b1);
    chk("t6_second", out_data, DW'(2));
    put(1'b0, '0, '0, 1'b1);
    put(1'b1, DW'(4), CW'(1), 1'b0);
    put(1'b1, DW'(5), CW'(1), 1'b0);
    flush = 1'b1;
    put(1'b0, '0, '0, 1'b0);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) put(1'b0, '0, '0, 1'b1);
`endif
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      bubble = ($urandom_range(0, 7) == 0);
      put(1'($urandom_range(0, 1)), DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
          CW'($urandom()), 1'($urandom_range(0, 3) != 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
